// File: rtl/dd_pkg.sv
// rtl/dd_pkg.sv - shared sample/window types for the feature window buffer and DrowsinessDetector
package dd_pkg;

    localparam int DATA_W = 10;
    localparam int WIN    = 30;
    localparam int CNT_W  = $clog2(WIN + 1);

    typedef logic [DATA_W-1:0] sample_t;

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        SHIFT = 2'd3
    } fwb_state_t;

endpackage

// File: rtl/feature_window_buffer_if.sv
// rtl/feature_window_buffer_if.sv - sample stream and detector-side signals of the feature window buffer
interface feature_window_buffer_if;
    import dd_pkg::*;

    sample_t            sample_in;
    logic               sample_valid;
    logic               sample_ready;
    logic               ann_done;
    sample_t            win_out [0:WIN-1];
    logic               start;
    logic [CNT_W-1:0]   fill_cnt;
    fwb_state_t         state;

    modport master (
        output sample_in, sample_valid, ann_done,
        input  sample_ready, win_out, start, fill_cnt, state
    );

    modport slave (
        input  sample_in, sample_valid, ann_done,
        output sample_ready, win_out, start, fill_cnt, state
    );

endinterface

// File: rtl/feature_window_buffer_dropout_filter.sv
// rtl/feature_window_buffer_dropout_filter.sv - replaces zero samples with the last non-zero one (DROPOUT_HOLD_EN), else pass-through
module dropout_filter
    import dd_pkg::*;
(
    input  logic    Clock,
    input  logic    Rst,
    input  sample_t sample_in,
    input  logic    xfer,
    output sample_t sample_out
);

`ifdef DROPOUT_HOLD_EN
    sample_t hold_q;
    sample_t hold_d;

    always_comb begin
        hold_d = hold_q;
        if (xfer && (sample_in != '0)) begin
            hold_d = sample_in;
        end
    end

    always_ff @(posedge Clock or negedge Rst) begin
        if (!Rst) begin
            hold_q <= '0;
        end else begin
            hold_q <= hold_d;
        end
    end

    // hold_q is still 0 until the first non-zero sample, so early dropouts store 0
    assign sample_out = (sample_in == '0) ? hold_q : sample_in;
`else
    logic unused_ok;
    assign unused_ok  = ^{Clock, Rst, xfer};
    assign sample_out = sample_in;
`endif

endmodule

// File: rtl/feature_window_buffer.sv
// rtl/feature_window_buffer.sv - builds the 30-sample detector window, issues start, slides by STRIDE on ann_done
// Optional feature: DROPOUT_HOLD_EN (see dropout_filter).
module feature_window_buffer
    import dd_pkg::*;
#(
    parameter int STRIDE = 10
) (
    input  logic                    Clock,
    input  logic                    Rst,
    feature_window_buffer_if.slave  bus
);

    fwb_state_t         state_q,    state_d;
    logic [CNT_W-1:0]   fill_cnt_q, fill_cnt_d;
    logic               start_q,    start_d;
    logic               ready_q,    ready_d;
    sample_t            win_q [0:WIN-1];
    sample_t            win_d [0:WIN-1];
    sample_t            filt_sample;
    logic               xfer;

    assign xfer = bus.sample_valid & ready_q;

    dropout_filter u_dropout_filter (
        .Clock      (Clock),
        .Rst        (Rst),
        .sample_in  (bus.sample_in),
        .xfer       (xfer),
        .sample_out (filt_sample)
    );

    always_comb begin
        state_d    = state_q;
        fill_cnt_d = fill_cnt_q;
        start_d    = start_q;
        win_d      = win_q;
        unique case (state_q)
            FILL: begin
                if (xfer) begin
                    win_d[fill_cnt_q] = filt_sample;
                    fill_cnt_d        = fill_cnt_q + CNT_W'(1);
                    if (fill_cnt_q == CNT_W'(WIN - 1)) begin
                        state_d = ISSUE;
                    end
                end
            end
            ISSUE: begin
                start_d = 1'b1;
                state_d = WAIT;
            end
            WAIT: begin
                if (bus.ann_done) begin
                    start_d = 1'b0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                // modulo keeps the index in range when STRIDE == WIN; the branch is dead then
                for (int i = 0; i < WIN; i++) begin
                    if (i < WIN - STRIDE) begin
                        win_d[i] = win_q[(i + STRIDE) % WIN];
                    end else begin
                        win_d[i] = '0;
                    end
                end
                fill_cnt_d = CNT_W'(WIN - STRIDE);
                state_d    = FILL;
            end
            default: state_d = FILL;
        endcase
        // registered ready tracks the upcoming state so it is low throughout reset
        ready_d = (state_d == FILL);
    end

    always_ff @(posedge Clock or negedge Rst) begin
        if (!Rst) begin
            state_q    <= FILL;
            fill_cnt_q <= '0;
            start_q    <= 1'b0;
            ready_q    <= 1'b0;
            for (int i = 0; i < WIN; i++) begin
                win_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            fill_cnt_q <= fill_cnt_d;
            start_q    <= start_d;
            ready_q    <= ready_d;
            win_q      <= win_d;
        end
    end

    assign bus.sample_ready = ready_q;
    assign bus.start        = start_q;
    assign bus.fill_cnt     = fill_cnt_q;
    assign bus.state        = state_q;
    assign bus.win_out      = win_q;

endmodule

// File: tb/tb_feature_window_buffer.sv
// tb/tb_feature_window_buffer.sv - directed self-checking bench for feature_window_buffer
module tb_feature_window_buffer;
    import dd_pkg::*;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_fail;

    feature_window_buffer_if bus ();

    feature_window_buffer #(.STRIDE(10)) dut (
        .Clock (clk),
        .Rst   (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        sample_t in_val;
        sample_t exp_val;
    } drop_vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input sample_t v);
        int n;
        n = 0;
        bus.sample_in    = v;
        bus.sample_valid = 1'b1;
        while (!bus.sample_ready && n < 50) begin
            tick();
            n++;
        end
        if (n >= 50) begin
            check("push_timeout", 32'd1, 32'd0);
        end
        tick();
        bus.sample_valid = 1'b0;
    endtask

    task automatic pulse_done();
        bus.ann_done = 1'b1;
        tick();
        bus.ann_done = 1'b0;
    endtask

    drop_vec_t dvec [6];

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        rst_n  = 1'b0;
        bus.sample_in    = '0;
        bus.sample_valid = 1'b0;
        bus.ann_done     = 1'b0;

`ifdef DROPOUT_HOLD_EN
        dvec = '{'{10'd0, 10'd0}, '{10'd284, 10'd284}, '{10'd281, 10'd281},
                 '{10'd0, 10'd281}, '{10'd0, 10'd281}, '{10'd298, 10'd298}};
`else
        dvec = '{'{10'd0, 10'd0}, '{10'd284, 10'd284}, '{10'd281, 10'd281},
                 '{10'd0, 10'd0}, '{10'd0, 10'd0}, '{10'd298, 10'd298}};
`endif

        // reset state
        repeat (2) tick();
        check("rst_start", bus.start, 0);
        check("rst_ready", bus.sample_ready, 0);
        check("rst_fill", bus.fill_cnt, 0);
        check("rst_state", bus.state, FILL);
        for (int i = 0; i < WIN; i++) check($sformatf("rst_win%0d", i), bus.win_out[i], 0);

        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("ready_after_rst", bus.sample_ready, 1);

        // ann_done during FILL is ignored
        pulse_done();
        check("fill_done_state", bus.state, FILL);
        check("fill_done_cnt", bus.fill_cnt, 0);
        check("fill_done_start", bus.start, 0);

        // test 1: stream 1..30
        for (int v = 1; v <= 30; v++) push(sample_t'(v));
        check("t1_ready_drop", bus.sample_ready, 0);
        check("t1_issue_state", bus.state, ISSUE);
        check("t1_start_early", bus.start, 0);
        // ann_done on the ISSUE-entry cycle is ignored
        pulse_done();
        check("t1_wait_state", bus.state, WAIT);
        check("t1_start", bus.start, 1);
        check("t1_fill", bus.fill_cnt, 30);
        check("t1_win0", bus.win_out[0], 1);
        check("t1_win29", bus.win_out[29], 30);

        // test 2: stall in WAIT
        bus.sample_in    = 10'd999;
        bus.sample_valid = 1'b1;
        for (int c = 0; c < 20; c++) begin
            tick();
            check($sformatf("t2_ready_c%0d", c), bus.sample_ready, 0);
        end
        bus.sample_valid = 1'b0;
        check("t2_start_held", bus.start, 1);
        check("t2_state_held", bus.state, WAIT);
        for (int i = 0; i < WIN; i++) check($sformatf("t2_frozen%0d", i), bus.win_out[i], i + 1);
        pulse_done();
        check("t2_start_drop", bus.start, 0);
        check("t2_shift_state", bus.state, SHIFT);
        tick();
        check("t2_back_fill", bus.state, FILL);
        check("t2_fill", bus.fill_cnt, 20);
        for (int i = 0; i < WIN; i++)
            check($sformatf("t2_shift%0d", i), bus.win_out[i], (i < 20) ? i + 11 : 0);

        // test 3: refill 31..40
        for (int v = 31; v <= 40; v++) push(sample_t'(v));
        check("t3_start_early", bus.start, 0);
        tick();
        check("t3_start", bus.start, 1);
        for (int i = 0; i < WIN; i++) check($sformatf("t3_win%0d", i), bus.win_out[i], i + 11);

        // reach WAIT again, then reset asynchronously mid-cycle
        pulse_done();
        tick();
        for (int v = 41; v <= 50; v++) push(sample_t'(v));
        tick();
        check("t5_pre_start", bus.start, 1);
        #3;
        rst_n = 1'b0;
        #1;
        check("t5_start", bus.start, 0);
        check("t5_fill", bus.fill_cnt, 0);
        check("t5_state", bus.state, FILL);
        check("t5_ready", bus.sample_ready, 0);
        for (int i = 0; i < WIN; i++) check($sformatf("t5_win%0d", i), bus.win_out[i], 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // test 4: dropout vectors into a fresh window
        for (int i = 0; i < 6; i++) push(dvec[i].in_val);
        check("t4_fill", bus.fill_cnt, 6);
        for (int i = 0; i < 6; i++) check($sformatf("t4_store%0d", i), bus.win_out[i], dvec[i].exp_val);

        // full 30 new samples needed before start rises
        for (int i = 0; i < 23; i++) push(sample_t'(100 + i));
        check("t5_fill29", bus.fill_cnt, 29);
        check("t5_state29", bus.state, FILL);
        check("t5_start29", bus.start, 0);
        push(10'd200);
        check("t5_issue", bus.state, ISSUE);
        tick();
        check("t5_start_new", bus.start, 1);
        check("t5_win29", bus.win_out[29], 200);
        check("t5_win6", bus.win_out[6], 100);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
